// File: rtl/psg_mix_scheduler.sv
// psg_mix_scheduler: shares one attenuation lookup across all PSG channels.
// On each sample_tick, every channel's level and attenuation control are
// snapshotted. The block then walks through them one channel per clock and
// feeds each to the external attenuator. The returned volumes are summed, and
// the mixed sample is emitted with a one-cycle valid strobe.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sample_tick      single-cycle request to start a mixing pass
//   channel_level    waveform bit per channel (bit k = channel k)
//   channel_att      attenuation per channel, channel k at [k*CONTROL_BITS +: CONTROL_BITS]
//   att_in           level driven to the shared attenuator (registered)
//   att_control      control driven to the shared attenuator (registered)
//   att_volume       combinational volume returned by the attenuator
//   sample           mixed sample, held between passes
//   sample_valid     one-cycle pulse when sample updates
//   busy             high while a pass is in progress
//   tick_dropped     one-cycle pulse when sample_tick arrives while busy
module psg_mix_scheduler #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CONTROL_BITS = 4,
  parameter int unsigned VOLUME_BITS  = 15,
  parameter int unsigned SAMPLE_BITS  = VOLUME_BITS + $clog2(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sample_tick,
  input  logic [CHANNELS-1:0]              channel_level,
  input  logic [CHANNELS*CONTROL_BITS-1:0] channel_att,
  output logic                             att_in,
  output logic [CONTROL_BITS-1:0]          att_control,
  input  logic [VOLUME_BITS-1:0]           att_volume,
  output logic [SAMPLE_BITS-1:0]           sample,
  output logic                             sample_valid,
  output logic                             busy,
  output logic                             tick_dropped
);

  localparam int unsigned IdxW = $clog2(CHANNELS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);

  typedef enum logic {StIdle, StScan} state_e;

  state_e                           state_q, state_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [SAMPLE_BITS-1:0]           acc_q, acc_d;
  logic [CHANNELS-1:0]              lvl_snap_q, lvl_snap_d;
  logic [CHANNELS*CONTROL_BITS-1:0] att_snap_q, att_snap_d;
  logic [SAMPLE_BITS-1:0]           sample_q, sample_d;
  logic                             valid_q, valid_d;
  logic                             busy_q, busy_d;
  logic                             drop_q, drop_d;
  logic                             att_in_q, att_in_d;
  logic [CONTROL_BITS-1:0]          att_ctrl_q, att_ctrl_d;

  logic [IdxW-1:0]        idx_next;
  logic [SAMPLE_BITS-1:0] vol_ext;

  assign idx_next = idx_q + 1'b1;
  assign vol_ext  = {{(SAMPLE_BITS - VOLUME_BITS){1'b0}}, att_volume};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    lvl_snap_d = lvl_snap_q;
    att_snap_d = att_snap_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    drop_d     = sample_tick & busy_q;
    att_in_d   = att_in_q;
    att_ctrl_d = att_ctrl_q;

    unique case (state_q)
      StIdle: begin
        att_in_d   = 1'b0;
        att_ctrl_d = '1;
        if (sample_tick) begin
          lvl_snap_d = channel_level;
          att_snap_d = channel_att;
          acc_d      = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = StScan;
          // Present channel 0 straight from the inputs; it matches the snapshot.
          att_in_d   = channel_level[0];
          att_ctrl_d = channel_att[CONTROL_BITS-1:0];
        end
      end
      StScan: begin
        acc_d = acc_q + vol_ext;
        idx_d = idx_next;
        if (idx_q == LastIdx) begin
          sample_d   = acc_q + vol_ext;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
          idx_d      = '0;
          att_in_d   = 1'b0;
          att_ctrl_d = '1;
        end else begin
          att_in_d   = lvl_snap_q[idx_next];
          att_ctrl_d = att_snap_q[int'(idx_next)*CONTROL_BITS +: CONTROL_BITS];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      lvl_snap_q <= '0;
      att_snap_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      att_in_q   <= 1'b0;
      att_ctrl_q <= '1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      lvl_snap_q <= lvl_snap_d;
      att_snap_q <= att_snap_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      att_in_q   <= att_in_d;
      att_ctrl_q <= att_ctrl_d;
    end
  end

  assign att_in       = att_in_q;
  assign att_control  = att_ctrl_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign tick_dropped = drop_q;

endmodule

// File: tb/tb_psg_mix_scheduler.sv
// Testbench for psg_mix_scheduler. A simple attenuator model answers
// att_in/att_control: 0 when the level is low or the control is 15, and
// otherwise 32767 - 2000*control.
module tb_psg_mix_scheduler;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [3:0]  channel_level;
  logic [15:0] channel_att;
  logic        att_in;
  logic [3:0]  att_control;
  logic [14:0] att_volume;
  logic [16:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        tick_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [14:0] att_model(input logic lvl, input logic [3:0] ctl);
    if (!lvl || ctl == 4'hF) return 15'd0;
    return 15'(32767 - 2000 * int'(ctl));
  endfunction

  assign att_volume = att_model(att_in, att_control);

  psg_mix_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .channel_level(channel_level),
    .channel_att  (channel_att),
    .att_in       (att_in),
    .att_control  (att_control),
    .att_volume   (att_volume),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .tick_dropped (tick_dropped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  level;
    logic [15:0] att;
    logic [16:0] exp_sample;
  } vec_t;

  vec_t vecs[7];

  // Run one pass. Inputs are scrambled every cycle after the tick, so only
  // the snapshot may influence the result.
  task automatic run_pass(input vec_t v);
    @(negedge clk);
    channel_level = v.level;
    channel_att   = v.att;
    sample_tick   = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    for (int k = 0; k < CH; k++) begin
      channel_level = 4'($urandom);
      channel_att   = 16'($urandom);
      @(negedge clk);
      chk("busy_in_pass", 32'(busy), 32'd1);
      chk("valid_in_pass", 32'(sample_valid), 32'd0);
      chk("att_in_seq", 32'(att_in), 32'(v.level[k]));
      chk("att_control_seq", 32'(att_control), 32'(v.att[k*4 +: 4]));
    end
    @(negedge clk);
    chk("valid_latency", 32'(sample_valid), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sample_value", 32'(sample), 32'(v.exp_sample));
    @(negedge clk);
    chk("valid_one_cycle", 32'(sample_valid), 32'd0);
    chk("sample_held", 32'(sample), 32'(v.exp_sample));
  endtask

  initial begin
    int n;
    vecs[0] = '{level: 4'hF, att: 16'h0000, exp_sample: 17'd131068};
    vecs[1] = '{level: 4'hB, att: 16'hEA50, exp_sample: 17'd60301};
    vecs[2] = '{level: 4'hF, att: 16'hFFFF, exp_sample: 17'd0};
    vecs[3] = '{level: 4'h0, att: 16'h0000, exp_sample: 17'd0};
    vecs[4] = '{level: 4'hF, att: 16'h0000, exp_sample: 17'd131068};
    vecs[5] = '{level: 4'h5, att: 16'h3311, exp_sample: 17'd57534};
    vecs[6] = '{level: 4'hF, att: 16'h1234, exp_sample: 17'd111068};

    rst_n = 1'b0;
    sample_tick = 1'b0;
    channel_level = 4'h0;
    channel_att = 16'h0;
    #12;
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(tick_dropped), 32'd0);
    chk("rst_att_in", 32'(att_in), 32'd0);
    chk("rst_att_control", 32'(att_control), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_pass(vecs[i]);

    // A dropped tick at E2, then a tick coincident with sample_valid.
    @(negedge clk);
    channel_level = 4'hF;
    channel_att = 16'h0000;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    @(negedge clk);
    chk("drop_none_c1", 32'(tick_dropped), 32'd0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    @(negedge clk);
    chk("drop_pulse", 32'(tick_dropped), 32'd1);
    chk("drop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("drop_once", 32'(tick_dropped), 32'd0);
    chk("drop_no_valid", 32'(sample_valid), 32'd0);
    @(negedge clk);
    chk("drop_pass_valid", 32'(sample_valid), 32'd1);
    chk("drop_pass_sample", 32'(sample), 32'd131068);
    channel_att = 16'hFFFF;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    chk("b2b_no_drop", 32'(tick_dropped), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 10);
    chk("b2b_valid_spacing", 32'(n), 32'd5);
    chk("b2b_sample", 32'(sample), 32'd0);

    // Full-scale pass, then reset two cycles after the next tick.
    run_pass(vecs[0]);
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_sample", 32'(sample), 32'd0);
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_att_control", 32'(att_control), 32'hF);
    chk("midrst_att_in", 32'(att_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(sample_valid), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
